// File: rtl/mux_nx1_rr_reg.sv
// mux_nx1_rr_reg
// N-channel, W-bit registered multiplexer with valid/ready handshaking on
// every input channel and on the output. One output register entry.
// Selection is either fixed (external Sel) or round-robin over the
// requesting channels, starting from an internal pointer.
//
// Ports:
//   Clk        rising-edge clock
//   Rst_n      synchronous active-low reset
//   In_Data    flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   In_Valid   per-channel valid
//   In_Ready   per-channel accept (one-hot or zero)
//   Mode       0 = fixed select via Sel, 1 = round-robin
//   Sel        channel index used when Mode = 0
//   Out_Data   registered data of the accepted channel
//   Out_Sel    index of the channel that produced Out_Data
//   Out_Valid  Out_Data / Out_Sel are valid
//   Out_Ready  consumer accepts the output when high with Out_Valid
module mux_nx1_rr_reg #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic [CHANNELS*WIDTH-1:0] In_Data,
    input  logic [CHANNELS-1:0]       In_Valid,
    output logic [CHANNELS-1:0]       In_Ready,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    output logic [WIDTH-1:0]          Out_Data,
    output logic [SEL_W-1:0]          Out_Sel,
    output logic                      Out_Valid,
    input  logic                      Out_Ready
);

    logic [WIDTH-1:0]    data_p0;
    logic [SEL_W-1:0]    sel_p0;
    logic                vld_p0;
    logic [SEL_W-1:0]    ptr;

    logic                load_en;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    gnt_idx;
    logic [WIDTH-1:0]    gnt_data;
    logic [SEL_W-1:0]    ptr_nxt;
    logic                xfer;
    logic                found;
    int                  idx;

    // The output register can take new data when empty or being drained.
    assign load_en = !vld_p0 | Out_Ready;

    // Grant: fixed mode ignores In_Valid (an out-of-range Sel grants nothing);
    // round-robin picks the first valid channel at or after ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (!Mode) begin
            if (int'(Sel) < CHANNELS) grant[Sel] = 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = int'(ptr) + i;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!found && In_Valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    // One-hot grant to index and data.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_nxt  = (int'(gnt_idx) == CHANNELS - 1) ? '0 : gnt_idx + 1'b1;
    assign In_Ready = Rst_n ? (grant & {CHANNELS{load_en}}) : '0;
    assign xfer     = |(In_Valid & In_Ready);

    // Stage p0: output register and round-robin pointer.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            data_p0 <= '0;
            sel_p0  <= '0;
            vld_p0  <= 1'b0;
            ptr     <= '0;
        end else begin
            if (load_en) begin
                vld_p0 <= xfer;
                if (xfer) begin
                    data_p0 <= gnt_data;
                    sel_p0  <= gnt_idx;
                end
            end
            if (xfer && Mode) ptr <= ptr_nxt;
        end
    end

    assign Out_Data  = data_p0;
    assign Out_Sel   = sel_p0;
    assign Out_Valid = vld_p0;

endmodule

// File: tb/tb_mux_nx1_rr_reg.sv
// Directed testbench for mux_nx1_rr_reg: a 4-channel instance covers reset,
// round-robin, skip, backpressure, fixed sweep and mid-stall reset; a
// 3-channel instance covers an out-of-range fixed select.
module tb_mux_nx1_rr_reg;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] In_Data;
    logic [3:0] In_Valid;
    logic [3:0] In_Ready;
    logic       Mode;
    logic [1:0] Sel;
    logic [1:0] Out_Data;
    logic [1:0] Out_Sel;
    logic       Out_Valid;
    logic       Out_Ready;

    logic [5:0] In_Data3;
    logic [2:0] In_Valid3;
    logic [2:0] In_Ready3;
    logic       Mode3;
    logic [1:0] Sel3;
    logic [1:0] Out_Data3;
    logic [1:0] Out_Sel3;
    logic       Out_Valid3;
    logic       Out_Ready3;

    int checks = 0;
    int errors = 0;

    logic [1:0] chd [4];
    logic [1:0] rr_seq [6];
    logic [1:0] sk_seq [4];

    always #5 Clk = ~Clk;

    mux_nx1_rr_reg #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Data(In_Data), .In_Valid(In_Valid),
        .In_Ready(In_Ready), .Mode(Mode), .Sel(Sel), .Out_Data(Out_Data),
        .Out_Sel(Out_Sel), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready)
    );

    mux_nx1_rr_reg #(.WIDTH(2), .CHANNELS(3), .SEL_W(2)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .In_Data(In_Data3), .In_Valid(In_Valid3),
        .In_Ready(In_Ready3), .Mode(Mode3), .Sel(Sel3), .Out_Data(Out_Data3),
        .Out_Sel(Out_Sel3), .Out_Valid(Out_Valid3), .Out_Ready(Out_Ready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        chd[0] = 2'b01; chd[1] = 2'b10; chd[2] = 2'b11; chd[3] = 2'b00;
        rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2;
        rr_seq[3] = 2'd3; rr_seq[4] = 2'd0; rr_seq[5] = 2'd1;
        sk_seq[0] = 2'd0; sk_seq[1] = 2'd2; sk_seq[2] = 2'd0; sk_seq[3] = 2'd2;

        Rst_n      = 1'b0;
        In_Data    = 8'b00_11_10_01;
        In_Valid   = 4'b1111;
        Mode       = 1'b1;
        Sel        = 2'd0;
        Out_Ready  = 1'b1;
        In_Data3   = 6'b11_10_01;
        In_Valid3  = 3'b111;
        Mode3      = 1'b0;
        Sel3       = 2'd0;
        Out_Ready3 = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        check("rst_in_ready", 32'(In_Ready), 32'h0);
        check("rst_out_valid", 32'(Out_Valid), 32'h0);
        check("rst_out_data", 32'(Out_Data), 32'h0);
        check("rst_out_sel", 32'(Out_Sel), 32'h0);

        // Release; first round-robin grant is channel 0
        Rst_n = 1'b1;
        #1;
        check("first_grant", 32'(In_Ready), 32'b0001);

        // Round-robin, all valid, 6 cycles
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_valid", 32'(Out_Valid), 32'h1);
            check("rr_sel", 32'(Out_Sel), 32'(rr_seq[i]));
            check("rr_data", 32'(Out_Data), 32'(chd[rr_seq[i]]));
        end

        // Backpressure with Out_Sel = 1 presented
        Out_Ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(In_Ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_sel", 32'(Out_Sel), 32'd1);
            check("bp_data", 32'(Out_Data), 32'b10);
            check("bp_valid", 32'(Out_Valid), 32'h1);
            check("bp_in_ready_hold", 32'(In_Ready), 32'h0);
            check("bp_ptr", 32'(dut.ptr), 32'd2);
        end
        Out_Ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(In_Ready), 32'b0100);
        tick();
        check("bp_release_sel", 32'(Out_Sel), 32'd2);
        check("bp_release_data", 32'(Out_Data), 32'b11);

        // Round-robin skip: only channels 0 and 2 valid (ptr is 3 here)
        In_Valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("skip_in_ready", 32'(In_Ready), (sk_seq[i] == 2'd0) ? 32'b0001 : 32'b0100);
            tick();
            check("skip_sel", 32'(Out_Sel), 32'(sk_seq[i]));
        end

        // Fixed sweep, ptr must hold at 3
        Mode     = 1'b0;
        In_Valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            Sel = 2'(i);
            tick();
            check("fix_sel", 32'(Out_Sel), 32'(i));
            check("fix_data", 32'(Out_Data), 32'(chd[i]));
        end
        check("fix_ptr_hold", 32'(dut.ptr), 32'd3);

        // Reset during a stall
        Mode = 1'b1;
        tick();
        check("pre_rst_sel_a", 32'(Out_Sel), 32'd3);
        tick();
        check("pre_rst_sel_b", 32'(Out_Sel), 32'd0);
        check("pre_rst_ptr", 32'(dut.ptr), 32'd1);
        Out_Ready = 1'b0;
        tick();
        check("stall_valid", 32'(Out_Valid), 32'h1);
        Rst_n = 1'b0;
        #1;
        check("rst_in_ready_comb", 32'(In_Ready), 32'h0);
        tick();
        check("mid_rst_valid", 32'(Out_Valid), 32'h0);
        check("mid_rst_ptr", 32'(dut.ptr), 32'd0);
        check("mid_rst_data", 32'(Out_Data), 32'h0);
        Rst_n     = 1'b1;
        Out_Ready = 1'b1;
        #1;
        check("post_rst_grant", 32'(In_Ready), 32'b0001);
        tick();
        check("post_rst_sel", 32'(Out_Sel), 32'd0);

        // 3-channel build: loaded from channel 0 and stalled, then Sel = 3
        check("c3_loaded_valid", 32'(Out_Valid3), 32'h1);
        check("c3_loaded_data", 32'(Out_Data3), 32'b01);
        Sel3 = 2'd3;
        #1;
        check("c3_oor_stall", 32'(In_Ready3), 32'h0);
        Out_Ready3 = 1'b1;
        #1;
        check("c3_oor_ready", 32'(In_Ready3), 32'h0);
        tick();
        check("c3_oor_drain", 32'(Out_Valid3), 32'h0);
        check("c3_hold_data", 32'(Out_Data3), 32'b01);
        check("c3_hold_sel", 32'(Out_Sel3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
